// File: rtl/conv_addr_sequencer.sv
// conv_addr_sequencer: address/handshake sequencer for a KERxKER convolution.
// Streams each channel into a ping-pong SRAM bank, walks taps, then writes back.
module conv_addr_sequencer #(
  parameter int IMG_MAX = 32,
  parameter int KER     = 3,
  parameter int CH_MAX  = 4,
  parameter int DRAM_AW = 16,
  parameter int SRAM_AW = 10
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [$clog2(IMG_MAX+1)-1:0]             cfg_img_w,
  input  logic [$clog2(CH_MAX+1)-1:0]              cfg_ch,
  input  logic [DRAM_AW-1:0]                       cfg_base,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  output logic                                     mem_req,
  input  logic                                     mem_gnt,
  output logic [DRAM_AW-1:0]                       mem_addr,
  output logic [1:0]                               sram_wen,
  output logic [SRAM_AW-1:0]                       sram_waddr,
  output logic [SRAM_AW-1:0]                       sram_raddr,
  output logic [1:0]                               pe_state,
  output logic [$clog2(IMG_MAX)-1:0]               i,
  output logic [$clog2(IMG_MAX)-1:0]               j,
  output logic                                     wrb_valid,
  input  logic                                     wrb_ready,
  output logic [$clog2(CH_MAX*IMG_MAX*IMG_MAX)-1:0] wrb_addr
);

  localparam int WW = $clog2(IMG_MAX + 1);
  localparam int CW = $clog2(CH_MAX + 1);
  localparam int IW = $clog2(IMG_MAX);
  localparam int XW = $clog2(IMG_MAX * IMG_MAX + 1);
  localparam int BW = $clog2(CH_MAX * IMG_MAX * IMG_MAX);
  localparam int KW = (KER > 1) ? $clog2(KER) : 1;

  localparam logic [WW-1:0] KER_W = WW'(KER);
  localparam logic [WW-1:0] IMG_W = WW'(IMG_MAX);
  localparam logic [CW-1:0] CH_C  = CW'(CH_MAX);
  localparam logic [KW-1:0] K_END = KW'(KER - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAC  = 3'd2,
    S_WRB  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WW-1:0]      r_w;
  logic [IW-1:0]      r_omax;
  logic [XW-1:0]      r_wsq;
  logic [CW-1:0]      r_clast;
  logic [CW-1:0]      r_c;
  logic [DRAM_AW-1:0] r_base;
  logic [DRAM_AW-1:0] r_ch_off;
  logic [XW-1:0]      r_idx;
  logic [IW-1:0]      r_i;
  logic [IW-1:0]      r_j;
  logic [KW-1:0]      r_r;
  logic [KW-1:0]      r_s;
  logic [BW-1:0]      r_wrb;
  logic               r_err;

  logic               w_cfg_ok;
  logic [XW-1:0]      w_wsq;
  logic               w_idx_last;
  logic               w_tap_last;
  logic               w_out_last;
  logic               w_ch_last;
  logic [DRAM_AW-1:0] w_mem_addr;
  logic [SRAM_AW-1:0] w_row;
  logic [SRAM_AW-1:0] w_col;
  logic [SRAM_AW-1:0] w_raddr;

  assign w_cfg_ok = (cfg_img_w >= KER_W) &&
                    (cfg_img_w <= IMG_W) &&
                    (cfg_ch != '0) &&
                    (cfg_ch <= CH_C);

  assign w_wsq      = XW'(cfg_img_w) * XW'(cfg_img_w);
  assign w_idx_last = (r_idx == r_wsq - XW'(1));
  assign w_tap_last = (r_r == K_END) && (r_s == K_END);
  assign w_out_last = (r_i == r_omax) && (r_j == r_omax);
  assign w_ch_last  = (r_c == r_clast);

  // channel offset is kept as a running sum, so c*W*W needs no multiplier
  assign w_mem_addr = r_base + r_ch_off + DRAM_AW'(r_idx);

  assign w_row   = SRAM_AW'(r_i) + SRAM_AW'(r_r);
  assign w_col   = SRAM_AW'(r_j) + SRAM_AW'(r_s);
  assign w_raddr = w_row * SRAM_AW'(r_w) + w_col;

  assign i   = r_i;
  assign j   = r_j;
  assign err = r_err;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state and per-state outputs
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    sram_wen   = 2'b11;
    sram_waddr = '0;
    sram_raddr = '0;
    wrb_valid  = 1'b0;
    wrb_addr   = '0;
    pe_state   = 2'd0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_cfg_ok ? S_LOAD : S_DONE;
      end
      S_LOAD: begin
        busy       = 1'b1;
        pe_state   = 2'd1;
        mem_req    = 1'b1;
        mem_addr   = w_mem_addr;
        sram_waddr = SRAM_AW'(r_idx);
        if (mem_gnt) begin
          sram_wen[r_c[0]] = 1'b0;
          if (w_idx_last) w_next = S_MAC;
        end
      end
      S_MAC: begin
        busy       = 1'b1;
        pe_state   = 2'd2;
        sram_raddr = w_raddr;
        if (w_tap_last) w_next = S_WRB;
      end
      S_WRB: begin
        busy      = 1'b1;
        pe_state  = 2'd3;
        wrb_valid = 1'b1;
        wrb_addr  = r_wrb;
        if (wrb_ready) begin
          if (!w_out_last)    w_next = S_MAC;
          else if (w_ch_last) w_next = S_DONE;
          else                w_next = S_LOAD;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // config latch, counters and write-back index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w      <= '0;
      r_omax   <= '0;
      r_wsq    <= '0;
      r_clast  <= '0;
      r_c      <= '0;
      r_base   <= '0;
      r_ch_off <= '0;
      r_idx    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_r      <= '0;
      r_s      <= '0;
      r_wrb    <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err    <= !w_cfg_ok;
            r_w      <= cfg_img_w;
            r_omax   <= IW'(cfg_img_w - KER_W);
            r_wsq    <= w_wsq;
            r_clast  <= cfg_ch - CW'(1);
            r_base   <= cfg_base;
            r_c      <= '0;
            r_ch_off <= '0;
            r_idx    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_r      <= '0;
            r_s      <= '0;
            r_wrb    <= '0;
          end
        end
        S_LOAD: begin
          if (mem_gnt) begin
            if (w_idx_last) r_idx <= '0;
            else            r_idx <= r_idx + XW'(1);
          end
        end
        S_MAC: begin
          if (r_s == K_END) begin
            r_s <= '0;
            if (r_r == K_END) r_r <= '0;
            else              r_r <= r_r + KW'(1);
          end else begin
            r_s <= r_s + KW'(1);
          end
        end
        S_WRB: begin
          if (wrb_ready) begin
            r_wrb <= r_wrb + BW'(1);
            if (r_j == r_omax) begin
              r_j <= '0;
              if (r_i == r_omax) begin
                r_i <= '0;
                if (!w_ch_last) begin
                  r_c      <= r_c + CW'(1);
                  r_ch_off <= r_ch_off + DRAM_AW'(r_wsq);
                end
              end else begin
                r_i <= r_i + IW'(1);
              end
            end else begin
              r_j <= r_j + IW'(1);
            end
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// tb_conv_addr_sequencer: table of jobs with hand-computed totals, plus a
// per-cycle address model and a mid-job reset sequence.
module tb_conv_addr_sequencer;

  localparam int IMG_MAX = 32;
  localparam int KER     = 3;
  localparam int CH_MAX  = 4;
  localparam int DRAM_AW = 16;
  localparam int SRAM_AW = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  cfg_img_w;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_base;
  logic        busy, done, err;
  logic        mem_req, mem_gnt;
  logic [15:0] mem_addr;
  logic [1:0]  sram_wen;
  logic [9:0]  sram_waddr, sram_raddr;
  logic [1:0]  pe_state;
  logic [4:0]  i, j;
  logic        wrb_valid, wrb_ready;
  logic [11:0] wrb_addr;

  always #5 clk = ~clk;

  conv_addr_sequencer #(
    .IMG_MAX(IMG_MAX), .KER(KER), .CH_MAX(CH_MAX),
    .DRAM_AW(DRAM_AW), .SRAM_AW(SRAM_AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_img_w(cfg_img_w), .cfg_ch(cfg_ch), .cfg_base(cfg_base),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_raddr(sram_raddr),
    .pe_state(pe_state), .i(i), .j(j),
    .wrb_valid(wrb_valid), .wrb_ready(wrb_ready), .wrb_addr(wrb_addr)
  );

  typedef struct {
    int w;
    int c;
    int base;
    int gmode;
    int rstall;
    int edone;
    int ebeats;
    int ewrbs;
    int emacs;
    int eerr;
  } vec_t;

  vec_t tv[9];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input vec_t v);
    int cyc, nb, nw, nm, tap, stall, o, wsq, rem, oi, oj, ra;
    bit got;
    o = v.w - KER + 1;
    wsq = v.w * v.w;
    nb = 0; nw = 0; nm = 0; tap = 0; stall = 0; cyc = 0; got = 0;
    @(negedge clk);
    start = 1'b1;
    cfg_img_w = 6'(v.w);
    cfg_ch = 3'(v.c);
    cfg_base = 16'(v.base);
    mem_gnt = 1'b1;
    wrb_ready = 1'b1;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 3 && busy) begin
        start = 1'b1;
        cfg_img_w = 6'd7;
        cfg_ch = 3'd1;
        cfg_base = 16'h0055;
      end
      mem_gnt = (v.gmode == 0) ? 1'b1 : (cyc % 2 == 0);
      wrb_ready = 1'b1;
      if (v.rstall > 0 && wrb_valid && nw == 0 && stall < v.rstall) begin
        wrb_ready = 1'b0;
        stall++;
      end
      #1;
      if (cyc == 1) chk("err_after_start", err, v.eerr);
      if (done) begin
        got = 1;
        chk("done_latency", cyc, v.edone);
        chk("busy_in_done", busy, 0);
        chk("err_at_done", err, v.eerr);
      end else begin
        chk("busy", busy, 1);
        if (mem_req) begin
          chk("mem_addr", mem_addr, (v.base + nb) % 65536);
          if (mem_gnt) begin
            chk("sram_wen", sram_wen, ((nb / wsq) % 2 == 1) ? 1 : 2);
            chk("sram_waddr", sram_waddr, nb % wsq);
            nb++;
          end else begin
            chk("sram_wen_stall", sram_wen, 3);
          end
        end else begin
          chk("sram_wen_off", sram_wen, 3);
        end
        if (pe_state == 2'd2) begin
          rem = nw % (o * o);
          oi = rem / o;
          oj = rem % o;
          ra = ((oi + tap / KER) * v.w + oj + tap % KER) % 1024;
          chk("sram_raddr", sram_raddr, ra);
          tap++;
          nm++;
        end
        if (wrb_valid) begin
          rem = nw % (o * o);
          chk("wrb_addr", wrb_addr, nw % 4096);
          chk("i", i, rem / o);
          chk("j", j, rem % o);
          chk("taps_per_out", tap, KER * KER);
          if (wrb_ready) begin
            nw++;
            tap = 0;
          end
        end
      end
    end
    chk("done_seen", got, 1);
    chk("beats", nb, v.ebeats);
    chk("wrbs", nw, v.ewrbs);
    chk("macs", nm, v.emacs);
    @(negedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("pe_state_idle", pe_state, 0);
    chk("err_hold", err, v.eerr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_wen"}, sram_wen, 3);
    chk({tag, "_waddr"}, sram_waddr, 0);
    chk({tag, "_raddr"}, sram_raddr, 0);
    chk({tag, "_pe_state"}, pe_state, 0);
    chk({tag, "_i"}, i, 0);
    chk({tag, "_j"}, j, 0);
    chk({tag, "_wrb_valid"}, wrb_valid, 0);
    chk({tag, "_wrb_addr"}, wrb_addr, 0);
  endtask

  initial begin
    bit hit;
    tv[0] = '{4, 1, 'h100, 0, 0, 57, 16, 4, 36, 0};
    tv[1] = '{4, 1, 'h100, 1, 0, 73, 16, 4, 36, 0};
    tv[2] = '{5, 2, 'h200, 0, 0, 231, 50, 18, 162, 0};
    tv[3] = '{4, 1, 'h100, 0, 5, 62, 16, 4, 36, 0};
    tv[4] = '{2, 1, 'h300, 0, 0, 1, 0, 0, 0, 1};
    tv[5] = '{4, 0, 'h300, 0, 0, 1, 0, 0, 0, 1};
    tv[6] = '{3, 1, 'hFFFA, 0, 0, 20, 9, 1, 9, 0};
    tv[7] = '{33, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    tv[8] = '{4, 5, 0, 0, 0, 1, 0, 0, 0, 1};

    reset = 1'b1;
    start = 1'b0;
    cfg_img_w = '0;
    cfg_ch = '0;
    cfg_base = '0;
    mem_gnt = 1'b0;
    wrb_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 9; k++) run_job(tv[k]);

    // abort a job during MAC of output (1,0)
    @(negedge clk);
    start = 1'b1;
    cfg_img_w = 6'd4;
    cfg_ch = 3'd1;
    cfg_base = 16'h0100;
    mem_gnt = 1'b1;
    wrb_ready = 1'b1;
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (pe_state == 2'd2 && i == 5'd1 && j == 5'd0) hit = 1;
    end
    chk("reach_mac_1_0", hit, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midjob");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      chk("no_done_in_reset", done, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    run_job(tv[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/conv_addr_sequencer.md
CONV_ADDR_SEQUENCER -- requirements
Module: conv_addr_sequencer

Interface
REQ-001 Parameter IMG_MAX, default 32: maximum square image dimension.
REQ-002 Parameter KER, default 3: square kernel dimension (fixed per build).
REQ-003 Parameter CH_MAX, default 4: maximum input channel count.
REQ-004 Parameter DRAM_AW, default 16: DRAM address width.
REQ-005 Parameter SRAM_AW, default 10: SRAM address width; 2**SRAM_AW >= IMG_MAX*IMG_MAX.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to run a job; sampled only in IDLE.
REQ-009 cfg_img_w  in  $clog2(IMG_MAX+1)  image dimension W; sampled with start.
REQ-010 cfg_ch  in  $clog2(CH_MAX+1)  channel count C; sampled with start.
REQ-011 cfg_base  in  DRAM_AW  DRAM base address; sampled with start.
REQ-012 busy  out  1  high from the cycle after accepted start until done.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  set with done when the config is illegal; cleared on next accepted start.
REQ-015 mem_req / mem_gnt  out/in  1/1  DRAM read handshake; a beat transfers when both are high.
REQ-016 mem_addr  out  DRAM_AW  DRAM read address.
REQ-017 sram_wen  out  2  active-low per-bank write enables (bank0, bank1).
REQ-018 sram_waddr / sram_raddr  out  SRAM_AW each  SRAM write / read address.
REQ-019 pe_state  out  2  0=IDLE, 1=LOAD, 2=MAC, 3=WRB.
REQ-020 i, j  out  $clog2(IMG_MAX) each  current output row / column.
REQ-021 wrb_valid / wrb_ready  out/in  1/1  write-back handshake.
REQ-022 wrb_addr  out  $clog2(CH_MAX*IMG_MAX*IMG_MAX)  write-back result address.

Function
REQ-023 FSM states: IDLE, LOAD, MAC, WRB, DONE; pe_state equals the current state code (DONE reports 0).
REQ-024 IDLE + start, with KER <= W <= IMG_MAX and 1 <= C <= CH_MAX: latch config, channel c=0, go to LOAD next cycle.
REQ-025 IDLE + start with an illegal config: go to DONE, set err, issue no mem_req and no writes.
REQ-026 start outside IDLE is ignored.
REQ-027 LOAD: mem_req=1; mem_addr = cfg_base + c*W*W + idx, with idx running 0..W*W-1.
  - idx advances only on mem_gnt.
  - mem_addr is held stable while mem_gnt is low.
REQ-028 LOAD write side: on each granted beat, sram_wen[c[0]]=0 (the other bit is 1) and sram_waddr=idx in the same cycle; bank ping-pongs per channel.
REQ-029 LOAD exit: after the beat with idx=W*W-1, go to MAC with i=j=r=s=0.
REQ-030 MAC: one kernel tap per cycle.
  - sram_raddr = (i+r)*W + (j+s), reading bank c[0].
  - s increments, wrapping to 0 and incrementing r; KER*KER cycles per output.
REQ-031 After tap r=s=KER-1: go to WRB.
  - wrb_valid=1, wrb_addr = c*O*O + i*O + j, where O = W-KER+1.
  - Hold WRB and all outputs until wrb_ready=1.
REQ-032 On WRB handshake: j increments.
  - j wraps at O-1 to 0 and increments i; then back to MAC.
  - After i=j=O-1: c increments and the FSM goes to LOAD, or to DONE if c=C-1.
REQ-033 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-034 All address arithmetic is unsigned and modulo its port width; no overflow flag.
REQ-035 Outputs not named active in a state hold their reset values: mem_req=0, sram_wen=2'b11, wrb_valid=0.

Reset
REQ-036 While reset is high, regardless of clk:
  - state=IDLE, busy=0, done=0, err=0, mem_req=0, wrb_valid=0, sram_wen=2'b11, pe_state=0.
  - All addresses, i, j and internal counters = 0.
REQ-037 Reset asserted mid-job aborts the job with no done pulse; the first accepted start after deassertion runs normally.

Verification
REQ-038 W=4, C=1, base=0x100, mem_gnt and wrb_ready always 1, start -> 16 LOAD cycles with mem_addr 0x100..0x10F, then 4 outputs x (9 MAC + 1 WRB); wrb_addr 0,1,2,3; done 57 cycles after start.
REQ-039 Same job with mem_gnt low on every other cycle -> mem_addr held across stalls, exactly 16 bank0 writes, sram_waddr 0..15 in order.
REQ-040 W=5, C=2 -> second LOAD starts at base+25 and writes bank1 (sram_wen=2'b01); wrb_addr runs 0..17.
REQ-041 wrb_ready held low 5 cycles on the first WRB -> wrb_valid, wrb_addr, i and j stable for those 5 cycles; no extra MAC cycles.
REQ-042 start with W=2 (< KER), and separately with C=0 -> done and err the cycle after start; mem_req never high.
REQ-043 Reset asserted during MAC of output (1,0) -> all outputs at reset values immediately; a following start runs the REQ-038 sequence exactly.
